vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel strobe, x/y counters, syncs, valid, frame tick
// All decoded outputs are registered from next-state counters so they move together with xPos/yPos.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pixStrobe,
  output logic [31:0] xPos,
  output logic [31:0] yPos,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [31:0]   H_ACT_U  = H_ACTIVE;
  localparam logic [31:0]   V_ACT_U  = V_ACTIVE;
  localparam logic [31:0]   HS_BEG   = H_ACTIVE + H_FP;
  localparam logic [31:0]   HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [31:0]   VS_BEG   = V_ACTIVE + V_FP;
  localparam logic [31:0]   VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_q, pix_d;
  logic          valid_q, valid_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_q, frame_d;
  logic          tick;
  logic [31:0]   x_ext, y_ext;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    x_d       = x_q;
    y_d       = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Decode the values the counters are about to take so outputs align with them.
    x_ext   = {{(32-XW){1'b0}}, x_d};
    y_ext   = {{(32-YW){1'b0}}, y_d};
    pix_d   = tick;
    valid_d = (x_ext < H_ACT_U) && (y_ext < V_ACT_U);
    hsync_d = ((x_ext >= HS_BEG) && (x_ext < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((y_ext >= VS_BEG) && (y_ext < VS_END)) ? SYNC_ON : ~SYNC_ON;
    frame_d = tick && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      x_q       <= H_LAST;
      y_q       <= V_LAST;
      pix_q     <= 1'b0;
      valid_q   <= 1'b0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_q     <= pix_d;
      valid_q   <= valid_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      frame_q   <= frame_d;
    end
  end

  assign pixStrobe  = pix_q;
  assign xPos       = {{(32-XW){1'b0}}, x_q};
  assign yPos       = {{(32-YW){1'b0}}, y_q};
  assign valid      = valid_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frameStart = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: default 640x480 plus two tiny rasters
// Expected outputs come from the clock count since reset release, mapped onto raster position.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic run;
  int   k;
  int   checks;
  int   failures;

  logic        p0, f0, v0, h0, s0;
  logic [31:0] x0, y0;
  logic        p1, f1, v1, h1, s1;
  logic [31:0] x1, y1;
  logic        p2, f2, v2, h2, s2;
  logic [31:0] x2, y2;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .pixStrobe(p0), .xPos(x0), .yPos(y0),
    .valid(v0), .hsync(h0), .vsync(s0), .frameStart(f0)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pixStrobe(p1), .xPos(x1), .yPos(y1),
    .valid(v1), .hsync(h1), .vsync(s1), .frameStart(f1)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .pixStrobe(p2), .xPos(x2), .yPos(y2),
    .valid(v2), .hsync(h2), .vsync(s2), .frameStart(f2)
  );

  logic [68:0] o0, o1, o2;
  assign o0 = {p0, f0, v0, h0, s0, x0, y0};
  assign o1 = {p1, f1, v1, h1, s1, x1, y1};
  assign o2 = {p2, f2, v2, h2, s2, x2, y2};

  // Output bundle as a function of clocks since release: pixel n = kk/div, raster is 1 pixel behind.
  function automatic logic [68:0] model(input int ha, hf, hs, hb, va, vf, vs, vb, pol, dv, kk);
    int ht, vt, p, q, x, y;
    logic pix, fs, val, hsy, vsy;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = kk / dv;
    pix = (kk > 0) && (kk % dv == 0);
    fs = 1'b0;
    if (p == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      q = (p - 1) % (ht * vt);
      x = q % ht;
      y = q / ht;
      fs = pix && (q == 0);
    end
    val = (x < ha) && (y < va);
    hsy = (x >= ha + hf && x < ha + hf + hs) ? pol[0] : ~pol[0];
    vsy = (y >= va + vf && y < va + vf + vs) ? pol[0] : ~pol[0];
    return {pix, fs, val, hsy, vsy, 32'(x), 32'(y)};
  endfunction

  function automatic logic [68:0] m0(input int kk);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 0, 4, kk);
  endfunction
  function automatic logic [68:0] m1(input int kk);
    return model(4, 1, 2, 1, 3, 1, 1, 1, 1, 3, kk);
  endfunction
  function automatic logic [68:0] m2(input int kk);
    return model(4, 1, 2, 1, 3, 1, 1, 1, 1, 1, kk);
  endfunction

  function automatic logic [68:0] pack(input logic pix, fs, val, hsy, vsy, input int x, y);
    return {pix, fs, val, hsy, vsy, 32'(x), 32'(y)};
  endfunction

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", name, k, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial k = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Per-cycle comparison plus frame spacing and line-0 statistics.
  logic measuring;
  int   hs_low0, val_hi0, last1, last2;
  always @(negedge clk) begin
    if (run) begin
      chk("dut0_cycle", o0, m0(k));
      chk("dut1_cycle", o1, m1(k));
      chk("dut2_cycle", o2, m2(k));
      if (!rst_n) begin
        last1 = 0;
        last2 = 0;
      end else begin
        if (f1) begin
          if (last1 > 0) chk_int("dut1_frame_period", k - last1, 48 * 3);
          last1 = k;
        end
        if (f2) begin
          if (last2 > 0) chk_int("dut2_frame_period", k - last2, 48);
          last2 = k;
        end
        if (measuring && k >= 4 && y0 == 32'd0) begin
          if (!h0) hs_low0++;
          if (v0)  val_hi0++;
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; run = 1'b0; measuring = 1'b0;
    hs_low0 = 0; val_hi0 = 0; last1 = 0; last2 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Hand-computed points that pin the model.
    chk("model_first_pixel", m0(4), pack(1, 1, 1, 1, 1, 0, 0));
    chk("model_hsync_start", m0(4 * 657), pack(1, 0, 0, 0, 1, 656, 0));
    chk("model_hsync_end",   m0(4 * 753), pack(1, 0, 0, 1, 1, 752, 0));
    chk("model_line_wrap",   m0(4 * 801), pack(1, 0, 1, 1, 1, 0, 1));
    chk("model_small_hsync", m1(3 * 6), pack(1, 0, 0, 1, 0, 5, 0));
    chk("model_small_vsync", m1(3 * 33), pack(1, 0, 0, 0, 1, 0, 4));
    chk("model_small_wrap",  m2(49), pack(1, 1, 1, 0, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    run = 1'b1;
    chk("reset_state", o0, pack(0, 0, 0, 1, 1, 799, 524));
    chk("reset_state_small", o1, pack(0, 0, 0, 0, 0, 7, 5));

    @(negedge clk);
    rst_n = 1'b1;
    measuring = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) chk("post_release_hold", o0, pack(0, 0, 0, 1, 1, 799, 524));
      else       chk("first_tick", o0, pack(1, 1, 1, 1, 1, 0, 0));
    end

    begin : wait_mid
      int n;
      n = 0;
      while (!(x0 == 32'd300 && y0 == 32'd2) && n < 20000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20000) begin
        failures++;
        checks++;
        $display("FAIL wait_x300_y2 got=timeout exp=reached");
      end
    end
    measuring = 1'b0;
    chk_int("line0_hsync_low_clks", hs_low0, 96 * 4);
    chk_int("line0_valid_clks", val_hi0, 640 * 4);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_mid_line", o0, pack(0, 0, 0, 1, 1, 799, 524));
    chk("async_reset_small", o2, pack(0, 0, 0, 0, 0, 7, 5));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) chk("restart_hold", o0, pack(0, 0, 0, 1, 1, 799, 524));
      else       chk("restart_first_tick", o0, pack(1, 1, 1, 1, 1, 0, 0));
    end

    repeat (500) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
